// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   MD_WIDTH    default operand / HI / LO width
//   CNT_W       iteration counter width
//   op_e        operation codes issued by the decoder
//   state_e     sequencer states
//   is_iter_op  true for the four operations that use the iterative datapath
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Codes 0..3 are the multi-cycle operations; 4/5 are the moves and 6/7 are reserved.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decoder <-> multiply/divide unit bundle: request side plus HI/LO/status readback.
// Latency: none (wires only).
// Backpressure: none in the bundle; the decoder stalls itself while busy is high.
//
// Signals:
//   start  request strobe; op/a/b are sampled on the same clock edge
//   op     operation code (muldiv_pkg::op_e encoding)
//   a, b   operands rs / rt
//   busy   iterative operation in progress
//   done   one-cycle pulse after HI/LO were written by a multiply or divide
//   hi, lo architectural HI / LO registers
interface muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Decoder side.
    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   is_div_i  0 = multiply step, 1 = divide step
//   acc_i     accumulator {upper, lower} (2*WIDTH bits)
//   opnd_i    multiplicand (multiply) or divisor (divide), magnitude
//   acc_o     accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_rem;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        // Multiply: upper half accumulates the product, lower half holds the
        // not-yet-consumed multiplier bits. The carry out of the add becomes the
        // new top bit as the whole accumulator shifts right.
        sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

        // Divide: upper half is the partial remainder, lower half the dividend
        // bits still to shift in (MSB first) with quotient bits filling from the
        // bottom. The shifted remainder is WIDTH+1 bits wide; when it is not
        // smaller than the divisor the difference fits in WIDTH bits, so modular
        // subtraction on the low WIDTH bits is exact.
        shifted_rem = acc_i[2*WIDTH-1:WIDTH-1];
        rem_ge      = shifted_rem >= {1'b0, opnd_i};
        rem_sub     = acc_i[2*WIDTH-2:WIDTH-1] - opnd_i;

        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (rem_ge) begin
                acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU over WIDTH steps, plus MTHI/MTLO).
// Latency: HI/LO written and done pulsed WIDTH+1 edges after the start edge; moves take one edge.
// Backpressure: none; any start while busy is dropped, so the decoder must stall on busy.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-low reset
//   bus   muldiv_if slave: start/op/a/b in, busy/done/hi/lo out
// WIDTH must match muldiv_pkg::MD_WIDTH, since the iteration counter is CNT_W bits wide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    // Request decode (only meaningful on an accepted start).
    logic               req_signed;
    logic               req_div;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               div_zero;

    // Fix-up results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_d)
    );

    always_comb begin
        req_signed = (bus.op == MULT) || (bus.op == DIV);
        req_div    = (bus.op == DIV)  || (bus.op == DIVU);
        sgn_a      = req_signed & bus.a[WIDTH-1];
        sgn_b      = req_signed & bus.b[WIDTH-1];
        abs_a      = sgn_a ? (~bus.a + 1'b1) : bus.a;
        abs_b      = sgn_b ? (~bus.b + 1'b1) : bus.b;
        div_zero   = (bus.b == '0);

        prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (is_iter_op(bus.op)) begin
                            // Both datapaths start from {0, |a|} with |b| as the
                            // step operand: multiplier / dividend in the low half.
                            acc_q    <= {{WIDTH{1'b0}}, abs_a};
                            opnd_q   <= abs_b;
                            is_div_q <= req_div;
                            // A divide by zero keeps the all-ones quotient even for
                            // signed operands, so suppress quotient negation there.
                            neg_lo_q <= (sgn_a ^ sgn_b) & ~(req_div & div_zero);
                            // Remainder follows the dividend's sign; the product
                            // uses neg_lo_q only.
                            neg_hi_q <= sgn_a;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else if (bus.op == MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        lo_q <= prod_fix[WIDTH-1:0];
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops vs a reference model.
// Latency: expects done exactly 33 negedges after the start edge for every multiply/divide.
// Backpressure: exercises starts issued while busy (dropped) and back-to-back starts in the done cycle.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tot = 0;
    int          n_bad = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural result of one op, from plain integer arithmetic.
    task automatic ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                p    = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p    = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 3'd2) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // k0 = negedges already elapsed since the start edge.
    task automatic wait_done(input int k0, input string tag);
        int k;
        int nb;
        k  = k0;
        nb = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'd33);
        chk({tag, "_busycyc"}, 64'(nb), 64'(33 - k0));
        chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_hl(input string tag);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic run_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        ref_calc(op, a, b);
        issue(op, a, b);
        wait_done(0, tag);
        check_hl(tag);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edge_vals [6];
        edge_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dn;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed results against literal expectations.
        run_iter(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max_hi_k", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("multu_max_lo_k", 64'(bus.lo), 64'h0000_0001);
        run_iter(MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg_hi_k", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo_k", 64'(bus.lo), 64'hFFFF_FFEB);
        run_iter(DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg_lo_k", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("div_neg_hi_k", 64'(bus.hi), 64'hFFFF_FFFF);
        run_iter(DIVU, 32'd5, 32'd0, "divu_zero");
        chk("divu_zero_lo_k", 64'(bus.lo), 64'hFFFF_FFFF);
        chk("divu_zero_hi_k", 64'(bus.hi), 64'd5);
        run_iter(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_lo_k", 64'(bus.lo), 64'h8000_0000);
        chk("div_ovf_hi_k", 64'(bus.hi), 64'd0);

        // MTHI then MTLO on consecutive edges.
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.a     = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        chk("mthi_lo_hold", 64'(bus.lo), 64'(m_lo));
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_done", 64'(bus.done), 64'd0);
        bus.op = MTLO;
        bus.a  = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        chk("mtlo_hi_hold", 64'(bus.hi), 64'h1234_5678);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        chk("mtlo_done", 64'(bus.done), 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // Requests while busy are dropped.
        ref_calc(DIVU, 32'd100, 32'd7);
        issue(DIVU, 32'd100, 32'd7);
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.a     = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("busy_hi_hold", 64'(bus.hi), 64'h1234_5678);
        bus.op = MULT;
        bus.a  = 32'd3;
        bus.b  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, "busy_ign");
        chk("busy_ign_lo_k", 64'(bus.lo), 64'd14);
        chk("busy_ign_hi_k", 64'(bus.hi), 64'd2);
        // Back-to-back start in the done cycle.
        chk("b2b_done_now", 64'(bus.done), 64'd1);
        run_iter(MULT, 32'hFFFF_0003, 32'h0001_2345, "b2b");

        // Reset mid-operation.
        issue(MULTU, 32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        dn   = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'd0);
        chk("midrst_hold_hi", 64'(bus.hi), 64'd0);
        run_iter(DIV, 32'hFFFF_FF9C, 32'd7, "after_rst");

        // Randomized mix of all op codes.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            if (is_iter_op(rop)) begin
                run_iter(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
            end else begin
                ref_calc(rop, ra, rb);
                issue(rop, ra, rb);
                check_hl($sformatf("rnd%0d_op%0d", i, rop));
                chk($sformatf("rnd%0d_busy", i), 64'(bus.busy), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
